// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill controller: FSM states,
// dataType encodings, address field positions and the byte-enable helper.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HIT_RD  = 3'd1,
        REFILL  = 3'd2,
        RESPOND = 3'd3,
        WRITE   = 3'd4
    } state_e;

    localparam logic [1:0] DT_WORD     = 2'b00;
    localparam logic [1:0] DT_BYTE     = 2'b01;
    localparam logic [1:0] DT_HALF     = 2'b10;
    localparam logic [1:0] DT_WORD_ALT = 2'b11;

    localparam int BYTE_OFF_LSB   = 0;
    localparam int WORD_OFF_LSB   = 2;
    localparam int INDEX_LSB      = 4;
    localparam int WORDS_PER_LINE = 4;

    function automatic logic [3:0] calc_be(input logic [1:0] dt, input logic [1:0] boff);
        case (dt)
            DT_BYTE: calc_be = 4'b0001 << boff;
            DT_HALF: calc_be = 4'b0011 << {boff[1], 1'b0};
            default: calc_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag, valid and data arrays of the direct-mapped cache: one combinational
// read port, a whole-line refill write and a byte-enabled single-word write.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [INDEX_WIDTH-1:0]             rd_index,
    input  logic [1:0]                         rd_offset,
    output logic                               rd_valid,
    output logic [TAG_WIDTH-1:0]               rd_tag,
    output logic [DATA_WIDTH-1:0]              rd_data,
    input  logic [INDEX_WIDTH-1:0]             wr_index,
    input  logic                               line_we,
    input  logic [TAG_WIDTH-1:0]               line_tag,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_data,
    input  logic                               word_we,
    input  logic [1:0]                         word_offset,
    input  logic [DATA_WIDTH/8-1:0]            word_be,
    input  logic [DATA_WIDTH-1:0]              word_data
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      valid_d;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS_PER_LINE];

    // A refill marks its line valid; valid bits are the only reset state.
    always_comb begin
        valid_d = valid_q;
        if (line_we) begin
            valid_d[wr_index] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_index] <= line_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_mem[wr_index][w] <= line_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (word_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (word_be[b]) begin
                    data_mem[wr_index][word_offset][8*b +: 8] <= word_data[8*b +: 8];
                end
            end
        end
    end

    // Single read port.
    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_mem[rd_index];
        rd_data  = data_mem[rd_index][rd_offset];
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped, write-through/no-allocate cache controller with 4-word line
// refill. Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    input  logic [1:0]            dataType,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);
    localparam int TAG_LSB   = INDEX_LSB + INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_wd_q, req_wd_d;
    logic [1:0]              req_dt_q, req_dt_d;
    logic [1:0]              fill_cnt_q, fill_cnt_d;
    logic [3*DATA_WIDTH-1:0] fill_buf_q, fill_buf_d;

    logic                    accept_s, hit_s, line_we_s, word_we_s;
    logic [ADDR_WIDTH-1:0]   lk_addr_s;
    logic                    rd_valid_s;
    logic [TAG_WIDTH-1:0]    rd_tag_s;
    logic [DATA_WIDTH-1:0]   rd_data_s, wd_lane_s;
    logic [3:0]              be_s;

    assign accept_s  = (state_q == IDLE) && cpu_req;
    assign hit_s     = rd_valid_s && (rd_tag_s == lk_addr_s[ADDR_WIDTH-1:TAG_LSB]);
    assign line_we_s = (state_q == REFILL) && mem_ack && (fill_cnt_q == 2'd3);
    assign word_we_s = (state_q == WRITE) && mem_ack && hit_s;
    assign be_s      = calc_be(req_dt_q, req_addr_q[BYTE_OFF_LSB +: 2]);

    // In IDLE the lookup uses the live address so a hit can be decided on accept.
    always_comb begin
        if (state_q == IDLE) begin
            lk_addr_s = cpu_addr;
        end else begin
            lk_addr_s = req_addr_q;
        end
    end

    // Move right-aligned sub-word write data onto its byte lanes.
    always_comb begin
        wd_lane_s = req_wd_q;
        case (req_dt_q)
            DT_BYTE: wd_lane_s = req_wd_q << {req_addr_q[1:0], 3'b000};
            DT_HALF: wd_lane_s = req_wd_q << {req_addr_q[1], 4'b0000};
            default: wd_lane_s = req_wd_q;
        endcase
    end

    cache_line_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (lk_addr_s[INDEX_LSB +: INDEX_WIDTH]),
        .rd_offset   (lk_addr_s[WORD_OFF_LSB +: 2]),
        .rd_valid    (rd_valid_s),
        .rd_tag      (rd_tag_s),
        .rd_data     (rd_data_s),
        .wr_index    (req_addr_q[INDEX_LSB +: INDEX_WIDTH]),
        .line_we     (line_we_s),
        .line_tag    (req_addr_q[ADDR_WIDTH-1:TAG_LSB]),
        .line_data   ({mem_rdata, fill_buf_q}),
        .word_we     (word_we_s),
        .word_offset (req_addr_q[WORD_OFF_LSB +: 2]),
        .word_be     (be_s),
        .word_data   (wd_lane_s)
    );

    // Request capture and refill buffering; the last refill word goes straight to the store.
    always_comb begin
        req_addr_d = req_addr_q;
        req_wd_d   = req_wd_q;
        req_dt_d   = req_dt_q;
        fill_cnt_d = fill_cnt_q;
        fill_buf_d = fill_buf_q;
        if (accept_s) begin
            req_addr_d = cpu_addr;
            req_wd_d   = cpu_wd;
            req_dt_d   = dataType;
        end else begin
            req_addr_d = req_addr_q;
        end
        if ((state_q == REFILL) && mem_ack) begin
            fill_cnt_d = fill_cnt_q + 2'd1;
            case (fill_cnt_q)
                2'd0:    fill_buf_d[0*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                2'd1:    fill_buf_d[1*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                2'd2:    fill_buf_d[2*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                default: fill_buf_d = fill_buf_q;
            endcase
        end else begin
            fill_cnt_d = fill_cnt_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cpu_req)    state_d = IDLE;
                else if (cpu_we) state_d = WRITE;
                else if (hit_s)  state_d = HIT_RD;
                else             state_d = REFILL;
            end
            HIT_RD:  state_d = IDLE;
            REFILL:  state_d = line_we_s ? RESPOND : REFILL;
            RESPOND: state_d = IDLE;
            WRITE:   state_d = mem_ack ? IDLE : WRITE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            req_wd_q   <= '0;
            req_dt_q   <= 2'b00;
            fill_cnt_q <= 2'd0;
            fill_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_wd_q   <= req_wd_d;
            req_dt_q   <= req_dt_d;
            fill_cnt_q <= fill_cnt_d;
            fill_buf_q <= fill_buf_d;
        end
    end

    // Output decode; everything idles at zero outside its owning state.
    always_comb begin
        cpu_ready  = (state_q == IDLE);
        cpu_rvalid = (state_q == HIT_RD) || (state_q == RESPOND);
        cpu_rd     = cpu_rvalid ? rd_data_s : '0;
        mem_req    = (state_q == REFILL) || (state_q == WRITE);
        mem_we     = (state_q == WRITE);
        mem_addr   = '0;
        mem_wd     = '0;
        mem_be     = 4'b0000;
        case (state_q)
            REFILL: mem_addr = {req_addr_q[ADDR_WIDTH-1:INDEX_LSB], fill_cnt_q, 2'b00};
            WRITE: begin
                mem_addr = {req_addr_q[ADDR_WIDTH-1:WORD_OFF_LSB], 2'b00};
                mem_wd   = wd_lane_s;
                mem_be   = be_s;
            end
            default: mem_addr = '0;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    // Saturating counters of accepted reads.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (accept_s && !cpu_we) begin
            if (hit_s) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
                else                         hit_count_d = hit_count_q;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
                else                          miss_count_d = miss_count_q;
            end
        end else begin
            hit_count_d = hit_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed requests push expected
// memory transactions and read data; negedge monitors pop and compare.
module tb_cache_refill_ctrl;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [1:0]  dataType;
    logic        cpu_ready, cpu_rvalid;
    logic [31:0] cpu_rd;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .dataType   (dataType),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rd     (cpu_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    mem_exp_t    exp_mem[$];
    logic [31:0] exp_rd[$];
    logic [31:0] bmem [0:16383];
    int ack_delay = 0;
    int wait_cnt  = 0;
    int rvalid_cnt = 0;
    int rvalid_cyc = 0;
    int ack_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Backing RAM: acks after ack_delay idle cycles of mem_req, applies writes.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 16384; i++) bmem[i] = 32'hC0DE0000 | (i << 2);
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = bmem[mem_addr[15:2]];
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) bmem[mem_addr[15:2]][8*b +: 8] = mem_wd[8*b +: 8];
                end
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    // Monitor: completed memory transactions and read responses.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            ack_cnt++;
            if (exp_mem.size() == 0) begin
                fail_now("mem_unexpected_transaction");
            end else begin
                mem_exp_t e;
                e = exp_mem.pop_front();
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_we", 32'(mem_we), 32'(e.we));
                if (e.we) begin
                    chk("mem_be", 32'(mem_be), 32'(e.be));
                    chk("mem_wd", mem_wd, e.wd);
                end
            end
        end
        if (cpu_rvalid) begin
            rvalid_cnt++;
            rvalid_cyc = cyc;
            if (exp_rd.size() == 0) fail_now("cpu_rvalid_unexpected");
            else                    chk("cpu_rd", cpu_rd, exp_rd.pop_front());
        end
    end

    task automatic push_read_line(input logic [15:0] base);
        for (int w = 0; w < 4; w++)
            exp_mem.push_back('{addr: base + 16'(w*4), we: 1'b0, be: 4'b0000, wd: 32'h0});
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] wd,
                         input logic [1:0] dt, output int acc);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wd = wd; dataType = dt;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail_now("accept_timeout");
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input int lat, input bit hold);
        int acc, start, vio;
        start = rvalid_cnt;
        vio   = 0;
        exp_rd.push_back(exp);
        issue(1'b0, a, 32'h0, 2'b00, acc);
        if (!hold) begin
            @(posedge clk);
            #1 cpu_req = 1'b0;
        end
        for (int i = 0; i < 300 && rvalid_cnt == start; i++) begin
            @(negedge clk);
            #1;
            if (rvalid_cnt == start && cpu_ready) vio++;
        end
        cpu_req = 1'b0;
        if (rvalid_cnt == start) fail_now("rvalid_timeout");
        else chk($sformatf("latency_%h", a), rvalid_cyc - acc, lat);
        chk($sformatf("ready_low_busy_%h", a), vio, 0);
        if (hold) begin
            repeat (4) @(posedge clk);
            chk("single_rvalid_held_req", rvalid_cnt - start, 1);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] wd, input logic [1:0] dt,
                            input logic [15:0] ea, input logic [3:0] ebe, input logic [31:0] ewd);
        int acc;
        bit done;
        exp_mem.push_back('{addr: ea, we: 1'b1, be: ebe, wd: ewd});
        issue(1'b1, a, wd, dt, acc);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = cpu_ready;
        end
        if (!done) fail_now("write_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, base;
        bit seen;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h0; cpu_wd = 32'h0; dataType = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_rd", cpu_rd, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;

        push_read_line(16'h0120);
        do_read(16'h0124, 32'hC0DE0124, 5, 1'b0);
`ifdef CACHE_STATS_EN
        chk("miss_count_1", 32'(miss_count), 32'd1);
        chk("hit_count_0", 32'(hit_count), 32'd0);
`endif
        do_read(16'h012C, 32'hC0DE012C, 1, 1'b0);
`ifdef CACHE_STATS_EN
        chk("hit_count_1", 32'(hit_count), 32'd1);
`endif

        do_write(16'h0125, 32'h000000AB, 2'b01, 16'h0124, 4'b0010, 32'h0000AB00);
        do_read(16'h0124, 32'hC0DEAB24, 1, 1'b0);
        do_write(16'h012E, 32'h00001234, 2'b10, 16'h012C, 4'b1100, 32'h12340000);
        do_read(16'h012C, 32'h1234012C, 1, 1'b0);
        do_write(16'h0128, 32'h55667788, 2'b11, 16'h0128, 4'b1111, 32'h55667788);
        do_read(16'h0128, 32'h55667788, 1, 1'b0);

        do_write(16'h0300, 32'hDEADBEEF, 2'b00, 16'h0300, 4'b1111, 32'hDEADBEEF);
        push_read_line(16'h0300);
        do_read(16'h0300, 32'hDEADBEEF, 5, 1'b0);

        push_read_line(16'h0220);
        do_read(16'h0224, 32'hC0DE0224, 5, 1'b0);
        push_read_line(16'h0120);
        do_read(16'h0124, 32'hC0DEAB24, 5, 1'b0);

        exp_mem.push_back('{addr: 16'h0340, we: 1'b0, be: 4'b0000, wd: 32'h0});
        exp_mem.push_back('{addr: 16'h0344, we: 1'b0, be: 4'b0000, wd: 32'h0});
        base = ack_cnt;
        issue(1'b0, 16'h0344, 32'h0, 2'b00, acc);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (ack_cnt == base + 2);
        end
        if (!seen) fail_now("second_refill_ack");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midfill_rst_mem_req", 32'(mem_req), 32'd0);
        chk("midfill_rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("midfill_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
`ifdef CACHE_STATS_EN
        chk("midfill_rst_miss_count", 32'(miss_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        push_read_line(16'h0340);
        do_read(16'h0344, 32'hC0DE0344, 5, 1'b0);

        ack_delay = 5;
        push_read_line(16'h0360);
        do_read(16'h0364, 32'hC0DE0364, 25, 1'b1);
        ack_delay = 0;

        repeat (3) @(posedge clk);
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
